// File: rtl/lcd_panel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_panel_sequencer
// Description : Power and link sequencer for the LVDS LCD output path.
//               Brings the panel up as VDD -> LVDS link -> backlight and
//               tears it down in reverse, with a programmable dwell per step.
//               An emergency fault drops every enable at once and enforces
//               the minimum VDD-off time before the next power-up.
// Options     : PANEL_SEQ_FRAME_ALIGN_EN - when defined, the backlight is
//               only switched on at a frame_start pulse (frame boundary).
//               When undefined, WAIT_FRAME lasts exactly one cycle and
//               frame_start is unused.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_panel_sequencer #(
  parameter int T_VDD_TO_LINK = 4,  // VDD on -> link enable (>=1)
  parameter int T_LINK_TO_BL  = 6,  // link enable -> backlight eligible (>=1)
  parameter int T_BL_TO_LINK  = 5,  // backlight off -> link off (>=1)
  parameter int T_LINK_TO_VDD = 3,  // link off -> VDD off (>=1)
  parameter int T_OFF_MIN     = 8,  // minimum VDD-off time (>=1)
  parameter int CW            = 24  // dwell counter width, all T_* < 2^CW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_req,
  input  logic       frame_start,
  input  logic       fault,
  output logic       panel_vdd_en,
  output logic       link_en,
  output logic       backlight_en,
  output logic       ready,
  output logic [2:0] state
);

  // Encoding is visible on the debug port, so values are fixed.
  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_VDD_UP     = 3'd1,
    S_LINK_UP    = 3'd2,
    S_WAIT_FRAME = 3'd3,
    S_ON         = 3'd4,
    S_BL_DOWN    = 3'd5,
    S_LINK_DOWN  = 3'd6,
    S_COOL       = 3'd7
  } state_t;

  // Counter reload values: a state with dwell T holds for exactly T edges,
  // so the counter starts at T-1 and the exit happens on the edge where it
  // reads zero.
  localparam logic [CW-1:0] c_LOAD_VDD_TO_LINK = CW'(T_VDD_TO_LINK - 1);
  localparam logic [CW-1:0] c_LOAD_LINK_TO_BL  = CW'(T_LINK_TO_BL - 1);
  localparam logic [CW-1:0] c_LOAD_BL_TO_LINK  = CW'(T_BL_TO_LINK - 1);
  localparam logic [CW-1:0] c_LOAD_LINK_TO_VDD = CW'(T_LINK_TO_VDD - 1);
  localparam logic [CW-1:0] c_LOAD_OFF_MIN     = CW'(T_OFF_MIN - 1);
  localparam logic [CW-1:0] c_ZERO             = '0;
  localparam logic [CW-1:0] c_ONE              = CW'(1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;

  logic w_dwell_done;
  logic w_abort;
  logic w_fault_hit;
  logic w_frame_ok;

  logic w_next_vdd;
  logic w_next_link;
  logic w_next_bl;
  logic w_next_ready;

  logic r_vdd;
  logic r_link;
  logic r_bl;
  logic r_ready;

  assign w_dwell_done = (r_cnt == c_ZERO);
  assign w_abort      = ~power_req;

  // Fault is only meaningful while something is powered; in OFF and COOL the
  // panel is already down and the off-time dwell must not be restarted.
  assign w_fault_hit  = fault && (r_state != S_OFF) && (r_state != S_COOL);

`ifdef PANEL_SEQ_FRAME_ALIGN_EN
  assign w_frame_ok = frame_start;
`else
  logic w_unused_frame_start;
  assign w_unused_frame_start = frame_start;
  assign w_frame_ok = 1'b1;
`endif

  // Next-state and dwell counter: fault beats everything, abort beats dwell
  // expiry and frame alignment, dwell expiry advances the sequence.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = w_dwell_done ? c_ZERO : (r_cnt - c_ONE);

    if (w_fault_hit) begin
      w_next_state = S_COOL;
      w_next_cnt   = c_LOAD_OFF_MIN;
    end else begin
      case (r_state)
        S_OFF: begin
          if (power_req) begin
            w_next_state = S_VDD_UP;
            w_next_cnt   = c_LOAD_VDD_TO_LINK;
          end
        end
        S_VDD_UP: begin
          if (w_abort) begin
            w_next_state = S_LINK_DOWN;
            w_next_cnt   = c_LOAD_LINK_TO_VDD;
          end else if (w_dwell_done) begin
            w_next_state = S_LINK_UP;
            w_next_cnt   = c_LOAD_LINK_TO_BL;
          end
        end
        S_LINK_UP: begin
          if (w_abort) begin
            w_next_state = S_LINK_DOWN;
            w_next_cnt   = c_LOAD_LINK_TO_VDD;
          end else if (w_dwell_done) begin
            w_next_state = S_WAIT_FRAME;
            w_next_cnt   = c_ZERO;
          end
        end
        S_WAIT_FRAME: begin
          if (w_abort) begin
            w_next_state = S_LINK_DOWN;
            w_next_cnt   = c_LOAD_LINK_TO_VDD;
          end else if (w_frame_ok) begin
            w_next_state = S_ON;
            w_next_cnt   = c_ZERO;
          end
        end
        S_ON: begin
          if (w_abort) begin
            w_next_state = S_BL_DOWN;
            w_next_cnt   = c_LOAD_BL_TO_LINK;
          end
        end
        // Teardown states run to completion; power_req is not looked at.
        S_BL_DOWN: begin
          if (w_dwell_done) begin
            w_next_state = S_LINK_DOWN;
            w_next_cnt   = c_LOAD_LINK_TO_VDD;
          end
        end
        S_LINK_DOWN: begin
          if (w_dwell_done) begin
            w_next_state = S_COOL;
            w_next_cnt   = c_LOAD_OFF_MIN;
          end
        end
        S_COOL: begin
          if (w_dwell_done) begin
            w_next_state = S_OFF;
            w_next_cnt   = c_ZERO;
          end
        end
        default: begin
          w_next_state = S_OFF;
          w_next_cnt   = c_ZERO;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered enables switch on
  // the same edge as the state register.
  always_comb begin
    w_next_vdd   = 1'b0;
    w_next_link  = 1'b0;
    w_next_bl    = 1'b0;
    w_next_ready = 1'b0;
    case (w_next_state)
      S_VDD_UP:     w_next_vdd = 1'b1;
      S_LINK_UP,
      S_WAIT_FRAME,
      S_BL_DOWN: begin
        w_next_vdd  = 1'b1;
        w_next_link = 1'b1;
      end
      S_ON: begin
        w_next_vdd   = 1'b1;
        w_next_link  = 1'b1;
        w_next_bl    = 1'b1;
        w_next_ready = 1'b1;
      end
      S_LINK_DOWN:  w_next_vdd = 1'b1;
      default: begin
        w_next_vdd   = 1'b0;
        w_next_link  = 1'b0;
        w_next_bl    = 1'b0;
        w_next_ready = 1'b0;
      end
    endcase
  end

  // State and dwell counter registers; reset parks the panel in OFF at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_cnt   <= c_ZERO;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Registered enables so no input reaches a board pin combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vdd   <= 1'b0;
      r_link  <= 1'b0;
      r_bl    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_vdd   <= w_next_vdd;
      r_link  <= w_next_link;
      r_bl    <= w_next_bl;
      r_ready <= w_next_ready;
    end
  end

  assign panel_vdd_en = r_vdd;
  assign link_en      = r_link;
  assign backlight_en = r_bl;
  assign ready        = r_ready;
  assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lcd_panel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_panel_sequencer
// Description : Self-checking bench for lcd_panel_sequencer: a vector table
//               for the nominal up/down cycle, hand sequences for aborts,
//               faults, async reset and frame alignment, then random traffic
//               against a phase/elapsed-time reference model.
// Options     : PANEL_SEQ_FRAME_ALIGN_EN selects frame-aligned expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_panel_sequencer;

  localparam int P_VL  = 4;
  localparam int P_LB  = 6;
  localparam int P_BLL = 5;
  localparam int P_LV  = 3;
  localparam int P_OFF = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       power_req;
  logic       frame_start;
  logic       fault;
  logic       panel_vdd_en;
  logic       link_en;
  logic       backlight_en;
  logic       ready;
  logic [2:0] state;

  always #5 clk = ~clk;

  lcd_panel_sequencer #(
    .T_VDD_TO_LINK(P_VL),
    .T_LINK_TO_BL (P_LB),
    .T_BL_TO_LINK (P_BLL),
    .T_LINK_TO_VDD(P_LV),
    .T_OFF_MIN    (P_OFF),
    .CW           (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .power_req   (power_req),
    .frame_start (frame_start),
    .fault       (fault),
    .panel_vdd_en(panel_vdd_en),
    .link_en     (link_en),
    .backlight_en(backlight_en),
    .ready       (ready),
    .state       (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase number (the documented debug encoding) plus the
  // number of edges spent in that phase.
  int m_phase = 0;
  int m_age   = 0;

  typedef struct {
    logic       pr;
    logic       fs;
    logic       flt;
    logic [2:0] st;
    logic       v;
    logic       l;
    logic       b;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic pr, input logic fs, input logic flt,
                     input logic [2:0] st, input logic v, input logic l, input logic b);
    vec_t e;
    e.pr = pr; e.fs = fs; e.flt = flt; e.st = st; e.v = v; e.l = l; e.b = b;
    tbl.push_back(e);
  endtask

  function automatic logic [6:0] dut_vec();
    return {state, panel_vdd_en, link_en, backlight_en, ready};
  endfunction

  function automatic logic [6:0] exp_vec(input logic [2:0] st, input logic v,
                                         input logic l, input logic b);
    return {st, v, l, b, b};
  endfunction

  // Dwell in edges for each timed phase.
  function automatic int dwell(input int ph);
    case (ph)
      1: return P_VL;
      2: return P_LB;
      5: return P_BLL;
      6: return P_LV;
      7: return P_OFF;
      default: return 1;
    endcase
  endfunction

  function automatic logic [6:0] model_vec();
    logic v, l, b;
    v = (m_phase >= 1) && (m_phase <= 6);
    l = (m_phase >= 2) && (m_phase <= 5);
    b = (m_phase == 4);
    return {3'(m_phase), v, l, b, b};
  endfunction

  task automatic model_step(input logic pr, input logic fs, input logic flt);
    int  nxt;
    bit  expired;
    bit  frame_ok;
    nxt = -1;
    expired = (m_age + 1 >= dwell(m_phase));
`ifdef PANEL_SEQ_FRAME_ALIGN_EN
    frame_ok = fs;
`else
    frame_ok = 1'b1;
`endif
    if (flt && m_phase != 0 && m_phase != 7) nxt = 7;
    else begin
      case (m_phase)
        0: if (pr) nxt = 1;
        1: if (!pr) nxt = 6; else if (expired) nxt = 2;
        2: if (!pr) nxt = 6; else if (expired) nxt = 3;
        3: if (!pr) nxt = 6; else if (frame_ok) nxt = 4;
        4: if (!pr) nxt = 5;
        5: if (expired) nxt = 6;
        6: if (expired) nxt = 7;
        default: if (expired) nxt = 0;
      endcase
    end
    if (nxt >= 0) begin
      m_phase = nxt;
      m_age   = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got {state,vdd,link,bl,ready}=%b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, take one rising edge, return at the next
  // falling edge with the model advanced.
  task automatic step(input logic pr, input logic fs, input logic flt);
    power_req   = pr;
    frame_start = fs;
    fault       = flt;
    @(posedge clk);
    model_step(pr, fs, flt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    power_req   = 1'b0;
    frame_start = 1'b0;
    fault       = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    m_phase = 0;
    m_age   = 0;
    rst_n   = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Nominal power-up then power-down, one row per clock edge.
    add(0,0,0, 3'd0, 0,0,0);
    add(1,0,0, 3'd1, 1,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0, 3'd1, 1,0,0);
    add(1,0,0, 3'd2, 1,1,0);
    add(1,1,0, 3'd2, 1,1,0);                 // pulse in LINK_UP is dropped
    for (int i = 0; i < 4; i++) add(1,0,0, 3'd2, 1,1,0);
    add(1,0,0, 3'd3, 1,1,0);
    add(1,1,0, 3'd4, 1,1,1);
    add(1,0,0, 3'd4, 1,1,1);
    add(0,0,0, 3'd5, 1,1,0);                 // backlight drops first
    for (int i = 0; i < 4; i++) add(0,0,0, 3'd5, 1,1,0);
    add(1,0,0, 3'd6, 1,0,0);                 // re-request ignored
    for (int i = 0; i < 2; i++) add(1,0,0, 3'd6, 1,0,0);
    add(1,0,0, 3'd7, 0,0,0);
    for (int i = 0; i < 7; i++) add(1,0,0, 3'd7, 0,0,0);
    add(1,0,0, 3'd0, 0,0,0);
    add(1,0,0, 3'd1, 1,0,0);
    add(1,0,1, 3'd7, 0,0,0);                 // fault in VDD_UP
    add(0,0,1, 3'd7, 0,0,0);                 // fault in COOL ignored

    rst_n = 1'b0;
    power_req = 1'b0; frame_start = 1'b0; fault = 1'b0;
    @(negedge clk);
    chk("reset_state", dut_vec(), exp_vec(3'd0, 0,0,0));
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].pr, tbl[i].fs, tbl[i].flt);
      chk($sformatf("table_row%0d", i), dut_vec(),
          exp_vec(tbl[i].st, tbl[i].v, tbl[i].l, tbl[i].b));
    end

    // Abort in LINK_UP, two cycles after the link rises.
    do_reset();
    for (int i = 0; i < 5; i++) step(1,0,0);
    chk("abort_link_up", dut_vec(), exp_vec(3'd2, 1,1,0));
    step(1,0,0);
    step(1,0,0);
    step(0,0,0);
    chk("abort_link_off", dut_vec(), exp_vec(3'd6, 1,0,0));
    step(0,0,0); step(0,0,0);
    step(0,0,0);
    chk("abort_vdd_off", dut_vec(), exp_vec(3'd7, 0,0,0));
    for (int i = 0; i < 7; i++) begin
      step(0,0,0);
      chk("abort_cool", dut_vec(), exp_vec(3'd7, 0,0,0));
    end
    step(0,0,0);
    chk("abort_off", dut_vec(), exp_vec(3'd0, 0,0,0));

    // Fault in ON with power_req held; a second fault inside COOL is ignored.
    do_reset();
    for (int i = 0; i < 12; i++) step(1,1,0);
    chk("fault_pre_on", dut_vec(), exp_vec(3'd4, 1,1,1));
    step(1,0,1);
    chk("fault_drop", dut_vec(), exp_vec(3'd7, 0,0,0));
    for (int i = 0; i < 7; i++) step(1,0,(i == 3));
    chk("fault_cool_hold", dut_vec(), exp_vec(3'd7, 0,0,0));
    step(1,0,0);
    chk("fault_to_off", dut_vec(), exp_vec(3'd0, 0,0,0));
    step(1,0,0);
    chk("fault_restart", dut_vec(), exp_vec(3'd1, 1,0,0));

    // Abort in WAIT_FRAME coinciding with a frame pulse.
    do_reset();
    for (int i = 0; i < 11; i++) step(1,0,0);
    chk("wf_reached", dut_vec(), exp_vec(3'd3, 1,1,0));
    step(0,1,0);
    chk("wf_abort_beats_frame", dut_vec(), exp_vec(3'd6, 1,0,0));

`ifdef PANEL_SEQ_FRAME_ALIGN_EN
    // Frame alignment: WAIT_FRAME holds until a pulse arrives.
    do_reset();
    for (int i = 0; i < 11; i++) step(1,(i == 7),0);
    chk("fa_link_pulse_ignored", dut_vec(), exp_vec(3'd3, 1,1,0));
    for (int i = 0; i < 4; i++) step(1,0,0);
    chk("fa_waiting", dut_vec(), exp_vec(3'd3, 1,1,0));
    step(1,1,0);
    chk("fa_on_at_frame", dut_vec(), exp_vec(3'd4, 1,1,1));
`endif

    // Asynchronous reset while in LINK_UP.
    do_reset();
    for (int i = 0; i < 6; i++) step(1,0,0);
    chk("rst_pre_link_up", dut_vec(), exp_vec(3'd2, 1,1,0));
    power_req = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("rst_async_clear", dut_vec(), exp_vec(3'd0, 0,0,0));
    @(negedge clk);
    m_phase = 0;
    m_age   = 0;
    rst_n   = 1'b1;
    step(1,0,0);
    chk("rst_restart", dut_vec(), exp_vec(3'd1, 1,0,0));

    // Random traffic against the reference model.
    do_reset();
    begin
      logic pr;
      pr = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) pr = ~pr;
        if ($urandom_range(0, 699) == 0) do_reset();
        step(pr, ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0));
        chk("random", dut_vec(), model_vec());
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
